// File: rtl/dbus_mem_resp_pkg.sv
// dbus_mem_resp_pkg: shared dbus request/response types, responder states and store-lane helpers
package dbus_mem_resp_pkg;

    localparam int DBUS_WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_OPS_SB = 2'd0,
        ST_OPS_SH = 2'd1,
        ST_OPS_SW = 2'd2
    } type_st_ops_e;

    typedef struct packed {
        logic [31:0]  addr;
        logic         ld_req;
        logic         st_req;
        logic [31:0]  w_data;
        type_st_ops_e st_ops;
    } type_lsu2dbus_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_dbus2lsu_s;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } type_dbus_resp_state_e;

    function automatic logic [3:0] st_be(input type_st_ops_e ops, input logic [1:0] lo);
        return (ops == ST_OPS_SB) ? 4'b0001 << lo :
               (ops == ST_OPS_SH) ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] st_wdata(input type_st_ops_e ops, input logic [31:0] w);
        return (ops == ST_OPS_SB) ? {4{w[7:0]}} :
               (ops == ST_OPS_SH) ? {2{w[15:0]}} : w;
    endfunction

    function automatic logic st_misaligned(input type_st_ops_e ops, input logic [1:0] lo);
        return (ops == ST_OPS_SB) ? 1'b0 :
               (ops == ST_OPS_SH) ? lo[0] : (lo != 2'b00);
    endfunction

endpackage

// File: rtl/dbus_mem_resp_bram.sv
// dbus_mem_resp_bram: single-port byte-write-enabled RAM with registered read, swappable for a macro
module dbus_mem_resp_bram #(
  parameter int DEPTH_WORDS = 4096,
  parameter     INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    w_data,
  output logic [31:0]                    r_data
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[addr][8*b +: 8] <= w_data[8*b +: 8];
    r_data <= mem[addr];
  end
endmodule

// File: rtl/dbus_mem_resp.sv
// dbus_mem_resp: dbus slave responder with wait states, range/alignment checks and byte-masked RAM
module dbus_mem_resp
    import dbus_mem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic           clk,
    input  logic           rst_n,
    input  type_lsu2dbus_s lsu2dbus_i,
    output type_dbus2lsu_s dbus2lsu_o,
    output logic           dbus_err_o
);

    localparam int                       AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]              LIMIT    = 33'(DEPTH_WORDS) << 2;
    localparam type_dbus_resp_state_e    FIRST    = (WAIT_CYCLES > 0) ? WAIT : RESP;
    localparam logic [DBUS_WAIT_W-1:0]   CNT_INIT = DBUS_WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    type_dbus_resp_state_e  state, state_nxt;
    logic [DBUS_WAIT_W-1:0] cnt, cnt_nxt;
    logic [31:0]            addr_q, w_data_q, off, ram_wd, ram_q;
    type_st_ops_e           ops_q;
    logic                   is_st_q, req, err;
    logic [AW-1:0]          ram_addr;
    logic [3:0]             ram_we;

    assign req = lsu2dbus_i.ld_req | lsu2dbus_i.st_req;
    assign off = addr_q - BASE_ADDR;
    assign err = ({1'b0, off} >= LIMIT) | (is_st_q & st_misaligned(ops_q, addr_q[1:0]));

    // In IDLE the live address feeds the RAM so a zero-wait read is ready in RESP.
    assign ram_addr = (state == IDLE) ? lsu2dbus_i.addr[AW+1:2] : off[AW+1:2];
    assign ram_we   = (state == RESP && is_st_q && !err) ? st_be(ops_q, addr_q[1:0]) : 4'b0000;
    assign ram_wd   = st_wdata(ops_q, w_data_q);

    assign dbus2lsu_o.ack    = (state == RESP);
    assign dbus2lsu_o.r_data = (state == RESP && !is_st_q && !err) ? ram_q : 32'h0;
    assign dbus_err_o        = (state == RESP) & err;

    // State, wait counter and request capture on acceptance in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            w_data_q <= '0;
            ops_q    <= ST_OPS_SB;
            is_st_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                addr_q   <= lsu2dbus_i.addr;
                w_data_q <= lsu2dbus_i.w_data;
                ops_q    <= lsu2dbus_i.st_ops;
                is_st_q  <= lsu2dbus_i.st_req;
            end
        end
    end

    // Next state: wait countdown, abandon on dropped request, single-cycle response.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req) begin
                state_nxt = FIRST;
                cnt_nxt   = CNT_INIT;
            end
            WAIT: begin
                state_nxt = !req ? IDLE : (cnt == '0) ? RESP : WAIT;
                cnt_nxt   = (req && cnt != '0) ? cnt - 1'b1 : cnt;
            end
            default: state_nxt = IDLE;
        endcase
    end

    dbus_mem_resp_bram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .w_data(ram_wd),
        .r_data(ram_q)
    );

endmodule

// File: tb/tb_dbus_mem_resp.sv
// tb_dbus_mem_resp: randomized bench against a byte-addressed memory model, three wait settings
module tb_dbus_mem_resp;
    import dbus_mem_resp_pkg::*;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          DW   = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    type_lsu2dbus_s req_s [3];
    type_dbus2lsu_s rsp_s [3];
    logic           err_s [3];
    logic [7:0]     bm [3][DW*4];
    int             tests = 0;
    int             fails = 0;
    logic [31:0]    rd, exp_w;
    logic           er;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dbus_mem_resp #(
            .DEPTH_WORDS(DW),
            .BASE_ADDR  (BASE),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 0))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .lsu2dbus_i(req_s[g]),
            .dbus2lsu_o(rsp_s[g]),
            .dbus_err_o(err_s[g])
        );
    end

    function automatic int wc(input int i);
        return i == 0 ? 1 : (i == 1 ? 3 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic st, input type_st_ops_e ops, input logic [31:0] a);
        logic [31:0] off = a - BASE;
        return (off >= 32'(DW*4)) ||
               (st && ((ops == ST_OPS_SH && a[0]) || (ops == ST_OPS_SW && a[1:0] != 2'b00)));
    endfunction

    function automatic logic [31:0] mword(input int i, input logic [31:0] a);
        int w = int'((a - BASE) & 32'(DW*4-4));
        return {bm[i][w+3], bm[i][w+2], bm[i][w+1], bm[i][w]};
    endfunction

    task automatic mstore(input int i, input type_st_ops_e ops, input logic [31:0] a, input logic [31:0] d);
        int n = ops == ST_OPS_SB ? 1 : (ops == ST_OPS_SH ? 2 : 4);
        int o = int'(a - BASE) & ~(n - 1);
        for (int k = 0; k < n; k++) bm[i][o+k] = d[8*k +: 8];
    endtask

    task automatic xact(input int i, input logic ld, input logic st, input type_st_ops_e ops,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic e);
        int   lat = 0;
        bit   got = 0;
        logic ee;
        req_s[i].addr   = a;
        req_s[i].w_data = d;
        req_s[i].st_ops = ops;
        req_s[i].ld_req = ld;
        req_s[i].st_req = st;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (rsp_s[i].ack) got = 1;
            else begin
                lat++;
                @(posedge clk);
                #1;
            end
        end
        r  = rsp_s[i].r_data;
        e  = err_s[i];
        ee = exp_err(st, ops, a);
        chk("ack_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(wc(i) + 1));
        chk("err", 32'(e), 32'(ee));
        if (!st) chk("r_data", r, ee ? 32'h0 : mword(i, a));
        if (st && !ee) mstore(i, ops, a, d);
        @(posedge clk);
        #1;
        chk("ack_one_cycle", 32'({rsp_s[i].ack, err_s[i]}), 32'd0);
        req_s[i].ld_req = 1'b0;
        req_s[i].st_req = 1'b0;
    endtask

    task automatic abandon(input int i, input logic [31:0] a, input logic [31:0] d, input int k);
        bit seen = 0;
        req_s[i].addr   = a;
        req_s[i].w_data = d;
        req_s[i].st_ops = ST_OPS_SW;
        req_s[i].ld_req = 1'b0;
        req_s[i].st_req = 1'b1;
        repeat (k) begin
            @(negedge clk);
            seen |= rsp_s[i].ack;
            @(posedge clk);
            #1;
        end
        req_s[i].st_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= rsp_s[i].ack | err_s[i];
        end
        @(posedge clk);
        #1;
        chk("abandon_noack", 32'(seen), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) req_s[i] = '0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack", 32'(rsp_s[i].ack), 32'd0);
            chk("rst_rdata", rsp_s[i].r_data, 32'h0);
            chk("rst_err", 32'(err_s[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++)
            for (int w = 0; w < DW; w++)
                xact(i, 1'b0, 1'b1, ST_OPS_SW, BASE + 32'(w*4), $urandom, rd, er);

        xact(0, 1'b0, 1'b1, ST_OPS_SW, 32'h2000_0010, 32'hDEAD_BEEF, rd, er);
        xact(0, 1'b1, 1'b0, ST_OPS_SW, 32'h2000_0010, 32'h0, rd, er);
        chk("tp_lw_deadbeef", rd, 32'hDEAD_BEEF);
        chk("tp_lw_err", 32'(er), 32'd0);
        xact(0, 1'b0, 1'b1, ST_OPS_SW, 32'h2000_0010, 32'h1122_3344, rd, er);
        xact(0, 1'b0, 1'b1, ST_OPS_SB, 32'h2000_0013, 32'h0000_00AA, rd, er);
        xact(0, 1'b1, 1'b0, ST_OPS_SW, 32'h2000_0010, 32'h0, rd, er);
        chk("tp_sb_merge", rd, 32'hAA22_3344);
        xact(0, 1'b0, 1'b1, ST_OPS_SH, 32'h2000_0012, 32'h0000_5566, rd, er);
        xact(0, 1'b1, 1'b0, ST_OPS_SW, 32'h2000_0010, 32'h0, rd, er);
        chk("tp_sh_merge", rd, 32'h5566_3344);
        xact(0, 1'b0, 1'b1, ST_OPS_SH, 32'h2000_0011, 32'h0000_7788, rd, er);
        chk("tp_sh_misaligned_err", 32'(er), 32'd1);
        xact(0, 1'b1, 1'b0, ST_OPS_SW, 32'h2000_0010, 32'h0, rd, er);
        chk("tp_misaligned_nowrite", rd, 32'h5566_3344);
        xact(0, 1'b1, 1'b0, ST_OPS_SW, 32'h1000_0000, 32'h0, rd, er);
        chk("tp_oor_err", 32'(er), 32'd1);
        chk("tp_oor_rdata", rd, 32'h0);
        xact(0, 1'b0, 1'b1, ST_OPS_SW, BASE + 32'h3FC, 32'hFEED_0001, rd, er);
        xact(0, 1'b1, 1'b0, ST_OPS_SW, BASE + 32'h3FC, 32'h0, rd, er);
        chk("tp_last_word", rd, 32'hFEED_0001);
        xact(0, 1'b1, 1'b0, ST_OPS_SW, BASE + 32'h400, 32'h0, rd, er);
        chk("tp_past_end_err", 32'(er), 32'd1);

        xact(1, 1'b0, 1'b1, ST_OPS_SW, BASE + 32'h20, 32'hCAFE_F00D, rd, er);
        abandon(1, BASE + 32'h20, 32'h1234_5678, 2);
        xact(1, 1'b1, 1'b0, ST_OPS_SW, BASE + 32'h20, 32'h0, rd, er);
        chk("tp_abandon_nowrite", rd, 32'hCAFE_F00D);

        xact(2, 1'b0, 1'b1, ST_OPS_SW, BASE, 32'h1, rd, er);
        xact(2, 1'b1, 1'b0, ST_OPS_SW, BASE, 32'h0, rd, er);
        chk("tp_b2b_raw", rd, 32'h1);

        exp_w = mword(1, BASE + 32'h24);
        req_s[1].addr   = BASE + 32'h24;
        req_s[1].w_data = 32'h0BAD_BEEF;
        req_s[1].st_ops = ST_OPS_SW;
        req_s[1].st_req = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ack", 32'(rsp_s[1].ack), 32'd0);
        req_s[1].st_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        xact(1, 1'b1, 1'b0, ST_OPS_SW, BASE + 32'h24, 32'h0, rd, er);
        chk("rst_wait_nowrite", rd, exp_w);

        begin
            bit got = 0;
            exp_w = mword(0, BASE + 32'h28);
            req_s[0].addr   = BASE + 32'h28;
            req_s[0].w_data = 32'h0BAD_F00D;
            req_s[0].st_ops = ST_OPS_SW;
            req_s[0].st_req = 1'b1;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                got = rsp_s[0].ack;
            end
            chk("rst_resp_ack_seen", 32'(got), 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            chk("rst_resp_ack_async", 32'(rsp_s[0].ack), 32'd0);
            req_s[0].st_req = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            xact(0, 1'b1, 1'b0, ST_OPS_SW, BASE + 32'h28, 32'h0, rd, er);
            chk("rst_resp_nowrite", rd, exp_w);
        end

        for (int n = 0; n < 450; n++) begin
            int          i = n % 3;
            int          r = $urandom_range(0, 19);
            logic [31:0] a;
            logic        st, ld;
            a = r == 0 ? 32'($urandom) :
                r == 1 ? BASE + 32'(DW*4) + 32'($urandom_range(0, 255)) :
                r == 2 ? BASE - 32'd1 - 32'($urandom_range(0, 255)) :
                         BASE + 32'($urandom_range(0, DW*4-1));
            st = 1'($urandom_range(0, 1));
            ld = st ? ($urandom_range(0, 9) == 0) : 1'b1;
            if (wc(i) > 0 && $urandom_range(0, 9) == 0)
                abandon(i, BASE + 32'($urandom_range(0, DW-1) * 4), $urandom, $urandom_range(1, wc(i)));
            else
                xact(i, ld, st, type_st_ops_e'($urandom_range(0, 2)), a, $urandom, rd, er);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
